// File: rtl/inv_pipe.sv
// inv_pipe: pipelined per-beat conditional bit inverter with valid/ready handshake,
// saturating completed-beat counter and sticky reserved-mode flag.
module inv_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_mask,
    input  logic [1:0]       in_mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             mode_err
);
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [WIDTH-1:0] xf;
    logic stall;
    assign stall     = v[DEPTH-1] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    always_comb xf = (in_mode == 2'd1) ? ~in_data : (in_mode == 2'd2) ? (in_data ^ in_mask) : in_data;
    // Stage data only loads behind a valid beat, so the last stage holds its value across bubbles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v        <= '0;
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
            beat_cnt <= '0;
            mode_err <= 1'b0;
        end else begin
            if (!stall) begin
                v[0] <= in_valid;
                if (in_valid) d[0] <= xf;
                for (int i = 1; i < DEPTH; i++) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) d[i] <= d[i-1];
                end
                if (in_valid && in_mode == 2'd3) mode_err <= 1'b1;
            end
            if (out_valid && out_ready && beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_inv_pipe.sv
// tb_inv_pipe: directed stimulus with a beat-queue scoreboard checked every cycle.
module tb_inv_pipe;
    localparam int W = 8;
    localparam int DEPTH = 2;
    logic clk = 0, rst_n = 0;
    logic [W-1:0] in_data = '0, in_mask = '0, out_data, sat_data;
    logic [1:0] in_mode = '0;
    logic in_valid = 0, out_ready = 1, in_ready, out_valid, mode_err;
    logic sat_in_ready, sat_out_valid, sat_mode_err;
    logic [15:0] beat_cnt;
    logic [1:0] sat_cnt;
    int errors = 0, checks = 0;
    always #5 clk = ~clk;

    inv_pipe #(.WIDTH(W), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_mask(in_mask), .in_mode(in_mode),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .beat_cnt(beat_cnt), .mode_err(mode_err));
    inv_pipe #(.WIDTH(W), .DEPTH(DEPTH), .CNT_W(2)) sat (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_mask(in_mask), .in_mode(in_mode),
        .in_valid(in_valid), .in_ready(sat_in_ready), .out_data(sat_data), .out_valid(sat_out_valid),
        .out_ready(out_ready), .beat_cnt(sat_cnt), .mode_err(sat_mode_err));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] xform(input logic [W-1:0] dd, input logic [W-1:0] mm, input logic [1:0] md);
        case (md)
            2'd1:    return ~dd;
            2'd2:    return dd ^ mm;
            default: return dd;
        endcase
    endfunction

    // Each accepted beat moves one stage per non-stalled edge; it is on the output once it has advanced DEPTH-1 times.
    typedef struct { logic [W-1:0] d; int age; } beat_t;
    beat_t q[$];
    int mcnt = 0;
    logic merr = 0, started = 0;
    logic [W-1:0] last = '0;

    always @(posedge clk) begin
        bit ev;
        started = 1;
        if (!rst_n) begin
            q.delete();
            mcnt = 0;
            merr = 0;
            last = '0;
        end else begin
            ev = q.size() > 0 && q[0].age >= DEPTH - 1;
            if (!(ev && !out_ready)) begin
                if (ev) begin
                    void'(q.pop_front());
                    mcnt++;
                end
                foreach (q[j]) q[j].age++;
                if (in_valid) begin
                    q.push_back('{xform(in_data, in_mask, in_mode), 0});
                    if (in_mode == 2'd3) merr = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit ev;
        if (started) begin
            ev = q.size() > 0 && q[0].age >= DEPTH - 1;
            chk("out_valid", out_valid, ev);
            chk("out_data", out_data, ev ? q[0].d : last);
            chk("in_ready", in_ready, !(ev && !out_ready));
            chk("beat_cnt", beat_cnt, mcnt);
            chk("sat_cnt", sat_cnt, mcnt > 3 ? 3 : mcnt);
            chk("mode_err", mode_err, merr);
            if (ev) last = q[0].d;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] dd, input logic [W-1:0] mm, input logic [1:0] md);
        in_data = dd;
        in_mask = mm;
        in_mode = md;
        in_valid = 1;
    endtask

    initial begin
        int i, k;
        bit acc;
        step();
        step();
        rst_n = 1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        // Basic pass / invert with two-cycle latency
        drive(8'hA5, 8'h00, 2'd1);
        step();
        drive(8'h0F, 8'h00, 2'd0);
        step();
        chk("t1_first", out_data, 8'h5A);
        chk("t1_first_valid", out_valid, 1);
        in_valid = 0;
        step();
        chk("t1_second", out_data, 8'h0F);
        step();
        chk("t1_idle_valid", out_valid, 0);
        chk("t1_hold", out_data, 8'h0F);
        chk("t1_cnt", beat_cnt, 2);
        chk("t1_sat_cnt", sat_cnt, 2);
        // Per-beat mode changes
        drive(8'hFF, 8'h3C, 2'd2);
        step();
        drive(8'h55, 8'hFF, 2'd0);
        step();
        chk("t2_masked", out_data, 8'hC3);
        drive(8'h55, 8'h00, 2'd1);
        step();
        drive(8'hAA, 8'hF0, 2'd2);
        step();
        chk("t2_inv", out_data, 8'hAA);
        in_valid = 0;
        step();
        chk("t2_mask2", out_data, 8'h5A);
        step();
        chk("t2_sat_cnt", sat_cnt, 3);
        // Stream with a three-cycle sink stall
        i = 0;
        k = 0;
        while (i < 6 && k < 50) begin
            drive(W'(8'h10 + i), 8'h0F, 2'(i % 3));
            out_ready = !(k >= 3 && k < 6);
            #1;
            acc = in_ready;
            if (k == 4) chk("t3_stall_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
            k++;
            if (acc) i++;
        end
        chk("t3_all_accepted", i, 6);
        in_valid = 0;
        out_ready = 1;
        repeat (4) step();
        chk("t3_cnt", beat_cnt, 12);
        // Reserved mode passes data through and latches the error flag
        drive(8'h12, 8'hFF, 2'd3);
        step();
        in_valid = 0;
        step();
        chk("t4_data", out_data, 8'h12);
        chk("t4_err", mode_err, 1);
        drive(8'h34, 8'h00, 2'd0);
        step();
        in_valid = 0;
        repeat (3) step();
        chk("t4_err_sticky", mode_err, 1);
        // Reset with beats in flight
        drive(8'h11, 8'h00, 2'd3);
        step();
        drive(8'h22, 8'h00, 2'd1);
        step();
        in_valid = 0;
        rst_n = 0;
        step();
        rst_n = 1;
        chk("t5_valid", out_valid, 0);
        chk("t5_cnt", beat_cnt, 0);
        chk("t5_err", mode_err, 0);
        chk("t5_in_ready", in_ready, 1);
        repeat (3) begin
            step();
            chk("t5_no_emerge", out_valid, 0);
        end
        chk("drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
